// File: rtl/tick_pulse_stretcher_if.sv
// Signal bundle between a tick source and tick_pulse_stretcher.
// The master drives the time base and event ticks; the slave returns the stretched level and status.
interface tick_pulse_stretcher_if #(
  parameter int PW = 4
);
  logic          en;
  logic          trig;
  logic          level;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output en,
    output trig,
    input  level,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  en,
    input  trig,
    output level,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/tick_pulse_stretcher.sv
// Stretches single-cycle event ticks into HIGH_CNT-tick level pulses, each followed by a LOW_CNT-tick gap.
// Ticks that arrive during a pulse or gap are queued in a saturating counter and replayed in order.
module tick_pulse_stretcher #(
  parameter int HIGH_CNT = 3,
  parameter int LOW_CNT  = 2,
  parameter int CW       = 8,
  parameter int PW       = 4
) (
  input logic                   clk,
  input logic                   reset,
  tick_pulse_stretcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CW-1:0] HighLast = CW'(HIGH_CNT - 1);
  localparam logic [CW-1:0] LowLast  = CW'(LOW_CNT - 1);
  localparam logic [PW-1:0] PendMax  = {PW{1'b1}};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;

  logic consume;
  logic directTrig;
  logic queueTrig;

  // Only en ticks seen while already in HIGH or LOW advance the counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    consume    = 1'b0;
    directTrig = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.trig) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (bus.en) begin
          if (cnt_q == HighLast) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOW: begin
        if (bus.en) begin
          if (cnt_q == LowLast) begin
            cnt_d = '0;
            if (pending_q != '0) begin
              state_d = HIGH;
              consume = 1'b1;
            end else if (bus.trig) begin
              state_d    = HIGH;
              directTrig = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A trig that coincides with a consume simply replaces the consumed entry.
  always_comb begin
    queueTrig  = bus.trig && (state_q != IDLE) && !directTrig;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (queueTrig && !consume) begin
      if (pending_q == PendMax) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PW'(1);
      end
    end else if (consume && !queueTrig) begin
      pending_d = pending_q - PW'(1);
    end
  end

  always_comb begin
    level_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.level    = level_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_tick_pulse_stretcher.sv
// Scoreboard bench for tick_pulse_stretcher: a default instance (PW=4) and a narrow-queue instance (PW=2).
module tb_tick_pulse_stretcher;

  localparam int HIGH_CNT = 3;
  localparam int LOW_CNT  = 2;
  localparam int PW_A     = 4;
  localparam int PW_B     = 2;
  localparam int PERIOD   = HIGH_CNT + LOW_CNT;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  tick_pulse_stretcher_if #(.PW(PW_A)) busA ();
  tick_pulse_stretcher_if #(.PW(PW_B)) busB ();

  tick_pulse_stretcher #(.HIGH_CNT(HIGH_CNT), .LOW_CNT(LOW_CNT), .CW(8), .PW(PW_A)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  tick_pulse_stretcher #(.HIGH_CNT(HIGH_CNT), .LOW_CNT(LOW_CNT), .CW(8), .PW(PW_B)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  typedef struct packed {
    logic            lvl;
    logic            bsy;
    logic [PW_A-1:0] pnd;
  } cyc_exp_t;

  typedef struct {
    int highEn;
    int lowEn;
    int highCyc;
    int lowCyc;
  } pulse_exp_t;

  cyc_exp_t   cycSb[$];
  pulse_exp_t pulseSb[$];
  int         countSb[$];

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs with en tied high; trig k happens at cycle t[k], cycle 0 is the first trig cycle.
  task automatic build_expected(input int n, input int t0, input int t1, input int t2);
    int t[3];
    int s[3];
    int last;
    cyc_exp_t e;
    t[0] = t0; t[1] = t1; t[2] = t2;
    for (int k = 0; k < n; k++) begin
      s[k] = t[k] + 1;
      if (k > 0 && s[k] < s[k-1] + PERIOD) s[k] = s[k-1] + PERIOD;
    end
    last = s[n-1] + PERIOD;
    for (int c = 1; c <= last; c++) begin
      int nT = 0;
      int nS = 0;
      e.lvl = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (c >= s[k] && c <= s[k] + HIGH_CNT - 1) e.lvl = 1'b1;
        if (t[k] + 1 <= c) nT++;
        if (s[k] <= c) nS++;
      end
      e.bsy = (c < last);
      e.pnd = PW_A'(nT - nS);
      cycSb.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    busA.trig = 1'b1; busA.en = 1'b1;
    busB.trig = 1'b1; busB.en = 1'b1;
    step(); step(); step();
    checks++;
    if ({busA.level, busA.busy, busA.pending, busA.overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_A: level/busy/pending/overflow = %b/%b/%0d/%b, expected 0/0/0/0",
               busA.level, busA.busy, busA.pending, busA.overflow);
    end
    checks++;
    if ({busB.level, busB.busy, busB.pending, busB.overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_B: level/busy/pending/overflow = %b/%b/%0d/%b, expected 0/0/0/0",
               busB.level, busB.busy, busB.pending, busB.overflow);
    end
    busA.trig = 1'b0; busA.en = 1'b0;
    busB.trig = 1'b0; busB.en = 1'b0;
    reset = 1'b1;
    step(); step();
    checks++;
    if (busA.busy !== 1'b0 || busB.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: busyA/busyB = %b/%b, expected 0/0", busA.busy, busB.busy);
    end
  endtask

  task automatic test_single_pulse();
    int c = 0;
    cyc_exp_t e;
    build_expected(1, 0, -1, -1);
    while (cycSb.size() > 0 && c < 100) begin
      busA.en   = 1'b1;
      busA.trig = (c == 0);
      step();
      c++;
      e = cycSb.pop_front();
      checks++;
      if (busA.level !== e.lvl || busA.busy !== e.bsy || busA.pending !== e.pnd) begin
        errors++;
        $display("[TB] FAIL single c%0d: level/busy/pending = %b/%b/%0d, expected %b/%b/%0d",
                 c, busA.level, busA.busy, busA.pending, e.lvl, e.bsy, e.pnd);
      end
    end
    busA.trig = 1'b0;
    if (cycSb.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL single_timeout: %0d entries left, expected 0", cycSb.size());
      cycSb.delete();
    end
    step();
  endtask

  task automatic test_slow_en();
    pulse_exp_t exp, got;
    bit seenBusy = 1'b0;
    bit done     = 1'b0;
    exp.highEn  = HIGH_CNT;
    exp.lowEn   = LOW_CNT;
    exp.highCyc = HIGH_CNT * 5;
    exp.lowCyc  = LOW_CNT * 5;
    pulseSb.push_back(exp);
    got = '{0, 0, 0, 0};
    for (int k = 0; k < 200 && !done; k++) begin
      busA.trig = (k == 0);
      busA.en   = (k % 5 == 0);
      if (busA.busy) seenBusy = 1'b1;
      if (busA.level) begin
        got.highCyc++;
        if (busA.en) got.highEn++;
      end else if (busA.busy) begin
        got.lowCyc++;
        if (busA.en) got.lowEn++;
      end
      step();
      if (seenBusy && !busA.busy) done = 1'b1;
    end
    busA.trig = 1'b0;
    busA.en   = 1'b0;
    exp = pulseSb.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL slow_timeout: busy=%b, expected pulse to finish", busA.busy);
    end
    checks++;
    if (got.highEn != exp.highEn || got.highCyc != exp.highCyc) begin
      errors++;
      $display("[TB] FAIL slow_high: en ticks/cycles = %0d/%0d, expected %0d/%0d",
               got.highEn, got.highCyc, exp.highEn, exp.highCyc);
    end
    checks++;
    if (got.lowEn != exp.lowEn || got.lowCyc != exp.lowCyc) begin
      errors++;
      $display("[TB] FAIL slow_low: en ticks/cycles = %0d/%0d, expected %0d/%0d",
               got.lowEn, got.lowCyc, exp.lowEn, exp.lowCyc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int c = 0;
    cyc_exp_t e;
    build_expected(3, 0, 1, 2);
    while (cycSb.size() > 0 && c < 100) begin
      busA.en   = 1'b1;
      busA.trig = (c <= 2);
      step();
      c++;
      e = cycSb.pop_front();
      checks++;
      if (busA.level !== e.lvl || busA.busy !== e.bsy || busA.pending !== e.pnd) begin
        errors++;
        $display("[TB] FAIL b2b c%0d: level/busy/pending = %b/%b/%0d, expected %b/%b/%0d",
                 c, busA.level, busA.busy, busA.pending, e.lvl, e.bsy, e.pnd);
      end
    end
    busA.trig = 1'b0;
    if (cycSb.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL b2b_timeout: %0d entries left, expected 0", cycSb.size());
      cycSb.delete();
    end
    step();
  endtask

  // Scenario 0 lands a trig on the gap exit with one event queued, scenario 1 with the queue empty.
  task automatic test_gap_exit();
    for (int sc = 0; sc < 2; sc++) begin
      int c = 0;
      int t0 = 0;
      int t1 = (sc == 0) ? 1 : PERIOD;
      int t2 = (sc == 0) ? PERIOD : -1;
      int n  = (sc == 0) ? 3 : 2;
      cyc_exp_t e;
      build_expected(n, t0, t1, t2);
      while (cycSb.size() > 0 && c < 100) begin
        busA.en   = 1'b1;
        busA.trig = (c == t0) || (c == t1) || (c == t2);
        step();
        c++;
        e = cycSb.pop_front();
        checks++;
        if (busA.level !== e.lvl || busA.busy !== e.bsy || busA.pending !== e.pnd) begin
          errors++;
          $display("[TB] FAIL gap_exit%0d c%0d: level/busy/pending = %b/%b/%0d, expected %b/%b/%0d",
                   sc, c, busA.level, busA.busy, busA.pending, e.lvl, e.bsy, e.pnd);
        end
      end
      busA.trig = 1'b0;
      if (cycSb.size() != 0) begin
        checks++; errors++;
        $display("[TB] FAIL gap_exit%0d_timeout: %0d entries left, expected 0", sc, cycSb.size());
        cycSb.delete();
      end
      step();
    end
  endtask

  task automatic test_saturation();
    int pulses;
    int expPulses;
    logic prev;
    int budget = 0;
    busA.en = 1'b0; busA.trig = 1'b0;
    busB.en = 1'b0;
    countSb.push_back(1 + (2 ** PW_B - 1));
    for (int k = 0; k < 5; k++) begin
      busB.trig = 1'b1;
      step();
    end
    busB.trig = 1'b0;
    checks++;
    if (busB.pending !== PW_B'(2 ** PW_B - 1) || busB.overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_fill: pending/overflow = %0d/%b, expected %0d/1",
               busB.pending, busB.overflow, 2 ** PW_B - 1);
    end
    busB.en = 1'b1;
    pulses  = busB.level ? 1 : 0;
    prev    = busB.level;
    while (busB.busy && budget < 200) begin
      step();
      budget++;
      if (busB.level && !prev) pulses++;
      prev = busB.level;
    end
    busB.en = 1'b0;
    expPulses = countSb.pop_front();
    checks++;
    if (busB.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_timeout: busy=%b, expected 0", busB.busy);
    end
    checks++;
    if (pulses != expPulses) begin
      errors++;
      $display("[TB] FAIL sat_pulses: pulses = %0d, expected %0d", pulses, expPulses);
    end
    checks++;
    if (busB.overflow !== 1'b1 || busB.pending !== '0) begin
      errors++;
      $display("[TB] FAIL sat_sticky: overflow/pending = %b/%0d, expected 1/0", busB.overflow, busB.pending);
    end
  endtask

  task automatic test_reset_mid();
    int highSeen = 0;
    busA.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      busA.trig = 1'b1;
      step();
    end
    busA.trig = 1'b0;
    checks++;
    if (busA.level !== 1'b1 || busA.pending !== PW_A'(2)) begin
      errors++;
      $display("[TB] FAIL rst_mid_setup: level/pending = %b/%0d, expected 1/2", busA.level, busA.pending);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({busA.level, busA.busy, busA.pending, busA.overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid_A: level/busy/pending/overflow = %b/%b/%0d/%b, expected 0/0/0/0",
               busA.level, busA.busy, busA.pending, busA.overflow);
    end
    checks++;
    if (busB.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_B_overflow: overflow = %b, expected 0", busB.overflow);
    end
    for (int k = 0; k < 15; k++) begin
      step();
      if (busA.level || busA.busy) highSeen++;
    end
    busA.en = 1'b0;
    checks++;
    if (highSeen != 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_after: active cycles = %0d, expected 0", highSeen);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busA.en = 1'b0; busA.trig = 1'b0;
    busB.en = 1'b0; busB.trig = 1'b0;
    test_reset();
    test_single_pulse();
    test_slow_en();
    test_back_to_back();
    test_gap_exit();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
